result_fifo: RTL
================

RESULT_FIFO -- requirements
Module: result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result entries; must be a power of two, 2..16.
REQ-002 SHALL have parameter WIDTH, default 16, datapath result width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port w, input, 1, CPU wait indicator; a 0->1 transition marks a completed instruction.
REQ-006 SHALL have port out_in, input, WIDTH, CPU result (register C).
REQ-007 SHALL have port zin/nin/vin, input, 1 each, CPU status Z, N, V.
REQ-008 SHALL have port pop, input, 1, user step request (level, e.g. from inverted KEY).
REQ-009 SHALL have port data_out, output, WIDTH, oldest stored result.
REQ-010 SHALL have port flags_out, output, 3, {Z,N,V} of oldest entry.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-012 SHALL have ports empty, full, overflow, output, 1 each.

Function
REQ-013 SHALL register w into w_q and pop into pop_q every cycle; push_ev = w & ~w_q, pop_ev = pop & ~pop_q.
REQ-014 SHALL, on a cycle with push_ev and not full, write {out_in, zin, nin, vin} as sampled at that same edge into the tail slot, advance tail.
REQ-015 SHALL, on a cycle with pop_ev and not empty, advance head; the popped entry is discarded.
REQ-016 SHALL wrap head and tail modulo DEPTH.
REQ-017 SHALL, with push_ev and pop_ev together and 0<count<DEPTH, perform both; count unchanged.
REQ-018 SHALL, with push_ev and pop_ev together when full, perform both (pop frees the slot); count stays DEPTH, overflow not set.
REQ-019 SHALL, with push_ev and pop_ev together when empty, perform the push only; count becomes 1.
REQ-020 SHALL, on push_ev alone when full, drop the result and set overflow; overflow stays 1 until reset.
REQ-021 SHALL ignore pop_ev when empty; no state change.
REQ-022 SHALL drive data_out/flags_out combinationally from the head slot; new head visible in the cycle after the writing/popping edge (latency 1 edge).
REQ-023 SHALL drive data_out = 0 and flags_out = 0 while empty.
REQ-024 SHALL assert empty iff count==0 and full iff count==DEPTH.
REQ-025 SHALL treat a held pop or held w as a single event (edge-only).

Reset
REQ-026 SHALL, on any clk edge with reset=1, set head=tail=0, count=0, overflow=0, w_q=1, pop_q=1; storage contents need not clear.
REQ-027 SHALL give reset priority over push_ev/pop_ev in the same cycle; a pending event is discarded.
REQ-028 SHALL not generate a push after reset release while w stays 1 (w_q reset to 1), nor a pop while pop is still held.

Configuration
REQ-029 SHALL, when RESULT_FIFO_SEG_EN is defined, add output seg, 7*(WIDTH/4) bits, active-low seven-segment codes of data_out nibbles (bits 6..0 = middle, upper-left, lower-left, bottom, lower-right, upper-right, top; hex 0-9, A, b, C, d, E, F), all segments off (7'b1111111) while empty.
REQ-030 SHALL, without RESULT_FIFO_SEG_EN, omit the seg port and decode logic entirely.

Structure
REQ-031 SHALL place DEPTH/WIDTH defaults, entry-width constant (WIDTH+3), and the 16 segment patterns plus blank code in shared package result_fifo_pkg.
REQ-032 SHALL implement nibble decoding in one sub-module hex_seg7 (4-bit in, 7-bit out, blank input), instantiated WIDTH/4 times under the macro only.

Verification
REQ-033 Reset, w=1 held 3 cycles after release -> count=0, empty=1, data_out=0000.
REQ-034 w 1->0->1 with out_in=16'h00A5, Z=0,N=0,V=0 -> next cycle count=1, data_out=00A5, flags_out=000.
REQ-035 Five w rising edges (values 1,2,3,4,5), DEPTH=4 -> count=4, full=1, overflow=1, data_out=0001; four pops -> 2,3,4, then empty.
REQ-036 Full FIFO, w rise (value 9) and pop rise same edge -> count=4, overflow=0, data_out=second-oldest, 9 at tail.
REQ-037 Empty FIFO, pop held 5 cycles plus simultaneous w rise (value 7) -> count=1, data_out=0007, no further pops.
REQ-038 RESULT_FIFO_SEG_EN defined, head=16'hBEEF -> seg digits b,E,E,F = 0000011,0000110,0000110,0001110; empty -> all 1111111.

Source files
------------

// File: rtl/result_fifo_pkg.sv
// result_fifo_pkg
//   Shared constants for the CPU result FIFO: default geometry, the width of
//   a stored entry (result plus Z/N/V flags) and the active-low
//   seven-segment patterns used by the optional display decoder.
//   Segment bit order (6..0): middle, upper-left, lower-left, bottom,
//   lower-right, upper-right, top.
package result_fifo_pkg;

   localparam int DEPTH_DEF = 4;
   localparam int WIDTH_DEF = 16;
   localparam int FLAG_W    = 3;

   // Each entry holds {result, Z, N, V}.
   function automatic int entry_w(input int width);
      return width + FLAG_W;
   endfunction

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] SEG_PAT [16] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

endpackage

// File: rtl/hex_seg7.sv
// hex_seg7
//   One-digit hex to active-low seven-segment decoder.
//   Ports:
//     hex_i   [3:0]  nibble to display
//     blank_i        1 = all segments off
//     seg_o   [6:0]  active-low segment drive (middle..top)
module hex_seg7
   import result_fifo_pkg::*;
(
   input  logic [3:0] hex_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   assign seg_o = blank_i ? SEG_BLANK : SEG_PAT[hex_i];

endmodule

// File: rtl/result_fifo.sv
// result_fifo
//   Captures CPU results (register C plus Z/N/V) each time the CPU wait line
//   rises, and lets the user step through them oldest-first with a pop
//   button. Both w and pop are edge-detected, so a held level counts once.
//   Optional feature: define RESULT_FIFO_SEG_EN to add the seg output with
//   seven-segment codes for every nibble of data_out.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     w                   CPU wait; 0->1 pushes {out_in, zin, nin, vin}
//     out_in [WIDTH-1:0]  CPU result
//     zin, nin, vin       CPU status flags
//     pop                 user step request (level)
//     data_out            oldest result (0 while empty)
//     flags_out [2:0]     {Z,N,V} of oldest entry (0 while empty)
//     count               occupancy
//     empty, full         occupancy status
//     overflow            sticky: a result was dropped while full
//     seg                 (RESULT_FIFO_SEG_EN only) active-low digit codes,
//                         digit k in seg[7k+6:7k] shows data_out[4k+3:4k]
module result_fifo
   import result_fifo_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int WIDTH = WIDTH_DEF
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     w,
   input  logic [WIDTH-1:0]         out_in,
   input  logic                     zin,
   input  logic                     nin,
   input  logic                     vin,
   input  logic                     pop,
   output logic [WIDTH-1:0]         data_out,
   output logic [2:0]               flags_out,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     overflow
`ifdef RESULT_FIFO_SEG_EN
   ,
   output logic [7*(WIDTH/4)-1:0]   seg
`endif
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = entry_w(WIDTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             w_q, pop_q;

   logic push_ev, pop_ev;
   logic do_push, do_pop;
   logic is_empty, is_full;
   logic [ENTRY_W-1:0] head_entry;

   assign push_ev  = w & ~w_q;
   assign pop_ev   = pop & ~pop_q;
   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == FULL_CNT);

   // A pop in the same cycle frees the slot, so a push into a full FIFO
   // still succeeds; a pop on an empty FIFO is ignored even if a push lands.
   assign do_pop  = pop_ev & ~is_empty;
   assign do_push = push_ev & (~is_full | do_pop);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (do_pop) begin
         head_d = head_q + PTR_W'(1);
      end
      if (do_push) begin
         tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (push_ev && !do_push) begin
         ovf_d = 1'b1;
      end
   end

   // Edge detectors reset to 1 so a line already high at release is not an event.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         w_q     <= 1'b1;
         pop_q   <= 1'b1;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         w_q     <= w;
         pop_q   <= pop;
      end
   end

   // Storage is not cleared by reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (!reset && do_push) begin
         mem_q[tail_q] <= {out_in, zin, nin, vin};
      end
   end

   assign head_entry = mem_q[head_q];
   assign data_out   = is_empty ? '0 : head_entry[ENTRY_W-1:FLAG_W];
   assign flags_out  = is_empty ? 3'b000 : head_entry[FLAG_W-1:0];
   assign count      = count_q;
   assign empty      = is_empty;
   assign full       = is_full;
   assign overflow   = ovf_q;

`ifdef RESULT_FIFO_SEG_EN
   for (genvar k = 0; k < WIDTH/4; k++) begin : g_digit
      hex_seg7 u_hex_seg7 (
         .hex_i   (data_out[4*k +: 4]),
         .blank_i (is_empty),
         .seg_o   (seg[7*k +: 7])
      );
   end
`endif

endmodule
